ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- AHB-Lite responder: word-addressed register memory sitting on the bus as a slave. It is the other end of the transfers that the master-side data buffer sources and sinks.
- Accepts pipelined address/data phases, inserts a programmable number of wait states, and returns a two-cycle ERROR response for illegal accesses.
- Target for integration testing of the master and its data buffer.

Parameters:
- Width, 32, data bus width (HWDATA/HRDATA).
- AddrWidth, 32, HADDR width.
- Depth, 16, number of Width-bit words; power of two, 2..256.
- WaitStates, 1, wait cycles per OKAY data phase; 0..7.

Ports:
- HCLK  input  1  bus clock, all logic on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  AddrWidth  byte address (address phase).
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  transfer size; 010 = word.
- HWDATA  input  Width  write data (data phase).
- HREADY  input  1  bus-wide ready; previous transfer complete.
- HRDATA  output  Width  read data.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (async, any time including mid-transfer): state IDLE, wait counter 0, all memory words 0, HRDATA=0, HREADYOUT=1, HRESP=0. A pending transfer is dropped and no memory write occurs.
- Accept: an address phase is accepted on a rising edge when HSEL & HREADY & HTRANS[1]. On accept, register the word index HADDR[log2(Depth)+1:2] and HWRITE.
- Legality: a transfer is illegal if any of the following holds: HADDR >= Depth*4; HADDR[1:0] != 0; HSIZE != 010.
- IDLE/BUSY or unselected: no access; HREADYOUT=1, HRESP=0 in the following cycle.
- States and transitions:
  - IDLE -> WAIT: legal accept with WaitStates>0.
  - IDLE -> DONE: legal accept with WaitStates==0.
  - IDLE -> ERR1: illegal accept.
  - WAIT: HREADYOUT=0, HRESP=0; counter loads WaitStates-1 on entry and decrements; counter==0 -> DONE.
  - DONE: HREADYOUT=1, HRESP=0; a new accept in the same cycle re-enters WAIT/DONE/ERR1, otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; a new accept re-enters as from IDLE, otherwise -> IDLE.
  - An OKAY data phase lasts WaitStates+1 cycles; an ERROR data phase lasts exactly 2 cycles.
- Write: HWDATA is sampled and mem[index] updated at the end of the DONE cycle. ERROR transfers never write.
- Read:
  - HRDATA is registered and valid throughout DONE; it is loaded on the edge that enters DONE.
  - HRDATA holds its last value in all other states.
  - ERROR transfers leave HRDATA unchanged.
- Hazard: if a read enters DONE on the same edge that commits a write to the same index, HRDATA takes HWDATA (forwarding). This matters for WaitStates==0 back-to-back write->read.
- Back-to-back: a new address phase overlapping the DONE or ERR2 cycle of the previous transfer is accepted. There are no bubble cycles beyond the wait states.
- HSEL low during another slave's data phase: HREADY low, so no accept; state is unaffected.

Optional Feature:
- Macro AHB_SLAVE_BYTE_LANE_EN.
- Defined:
  - HSIZE 000 (byte) and 001 (halfword) are legal. Halfword requires HADDR[0]==0.
  - Writes update only the addressed byte lanes, little-endian: HWDATA[8*k+7:8*k] -> byte k.
  - Reads always return the full word.
- Undefined: any HSIZE other than 010 gets the ERROR response.

Test Plan:
- Reset then NONSEQ read addr 0x0, WaitStates=1 -> one cycle HREADYOUT=0, then HREADYOUT=1, HRESP=0, HRDATA=0x00000000.
- NONSEQ write 0x8 data 0xDEADBEEF, then NONSEQ read 0x8 pipelined in the write's DONE cycle -> read returns 0xDEADBEEF. Repeat with WaitStates=0 -> forwarding still returns 0xDEADBEEF.
- Read 0x40 with Depth=16 (out of range) -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. Memory unchanged; the following legal read of 0x0 completes OKAY.
- Write 0x4 data 0x11223344, HSIZE=000 at 0x5 with HWDATA=0x0000AA00 -> with AHB_SLAVE_BYTE_LANE_EN, read 0x4 = 0x1122AA44. Without it, an ERROR response and read 0x4 = 0x11223344.
- Burst of SEQ writes 0x0..0x3C (16 words, values 1..16), then SEQ reads -> reads return 1..16 in order, each data phase lasting WaitStates+1 cycles.
- Assert HRESET during WAIT of a write to 0xC with data 0x55 -> outputs immediately reset (HREADYOUT=1, HRESP=0, HRDATA=0); subsequent read of 0xC = 0x00000000.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// ahb_slave_mem
//   AHB-Lite responder backed by a small word-addressed register memory.
//   Accepts pipelined address/data phases, stretches every OKAY data phase by
//   WaitStates cycles and answers illegal accesses with the two-cycle ERROR
//   response. Intended as the far end of master/data-buffer integration tests.
//
//   Optional feature macro: AHB_SLAVE_BYTE_LANE_EN
//     defined   : byte and halfword transfers are legal; writes update only the
//                 addressed byte lanes (little-endian), reads return the word.
//     undefined : only word transfers are legal.
//
// Parameters
//   Width      data bus width
//   AddrWidth  HADDR width
//   Depth      number of Width-bit words (power of two, 2..256)
//   WaitStates wait cycles inserted per OKAY data phase (0..7)
//
// Ports
//   HCLK       bus clock, rising edge
//   HRESET     asynchronous active-high reset
//   HSEL       slave select
//   HADDR      byte address (address phase)
//   HTRANS     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     1 = write
//   HSIZE      transfer size
//   HWDATA     write data (data phase)
//   HREADY     bus-wide ready
//   HRDATA     registered read data
//   HREADYOUT  slave ready
//   HRESP      0 OKAY, 1 ERROR
// ----------------------------------------------------------------------------
module ahb_slave_mem #(
   parameter int Width      = 32,
   parameter int AddrWidth  = 32,
   parameter int Depth      = 16,
   parameter int WaitStates = 1
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 HSEL,
   input  logic [AddrWidth-1:0] HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic [Width-1:0]     HWDATA,
   input  logic                 HREADY,
   output logic [Width-1:0]     HRDATA,
   output logic                 HREADYOUT,
   output logic                 HRESP
);

   localparam int IW = $clog2(Depth);
   localparam int NB = Width / 8;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_DONE = 3'd2;
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;

   // Counter reload on WAIT entry; the guard keeps WaitStates==0 from wrapping.
   localparam logic [2:0] WS_LOAD = (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;
   localparam logic [AddrWidth-1:0] ADDR_LIMIT = AddrWidth'(Depth * 4);

   logic [2:0]       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             write_q, write_d;
   logic [NB-1:0]    strb_q, strb_d;
   logic [Width-1:0] hrdata_q, hrdata_d;
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];

   logic             accept;
   logic             legal;
   logic [IW-1:0]    addr_idx;
   logic [NB-1:0]    acc_strb;
   logic             mem_we;
   logic [Width-1:0] wr_word;
   logic             unused_htrans0;

   assign unused_htrans0 = HTRANS[0];

   assign accept   = HSEL & HREADY & HTRANS[1];
   assign addr_idx = HADDR[IW+1:2];

   // Legality and byte-lane strobes of the transfer in the address phase.
   always_comb begin
      legal    = (HADDR < ADDR_LIMIT);
      acc_strb = '1;
`ifdef AHB_SLAVE_BYTE_LANE_EN
      case (HSIZE)
         3'b000: acc_strb = NB'(1) << HADDR[1:0];
         3'b001: begin
            acc_strb = NB'(3) << {HADDR[1], 1'b0};
            if (HADDR[0]) legal = 1'b0;
         end
         3'b010: if (HADDR[1:0] != 2'b00) legal = 1'b0;
         default: legal = 1'b0;
      endcase
`else
      if (HSIZE != 3'b010 || HADDR[1:0] != 2'b00) legal = 1'b0;
`endif
   end

   // Write commits at the end of DONE; unaddressed lanes keep the old bytes.
   assign mem_we = (state_q == ST_DONE) && write_q;

   always_comb begin
      wr_word = mem_q[idx_q];
      for (int k = 0; k < NB; k++) begin
         if (strb_q[k]) wr_word[8*k +: 8] = HWDATA[8*k +: 8];
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (mem_we) mem_d[idx_q] = wr_word;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      write_d  = write_q;
      strb_d   = strb_q;
      hrdata_d = hrdata_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            state_d = ST_IDLE;
            if (accept) begin
               idx_d   = addr_idx;
               write_d = HWRITE;
               strb_d  = acc_strb;
               if (!legal) begin
                  state_d = ST_ERR1;
               end else if (WaitStates == 0) begin
                  state_d = ST_DONE;
                  // Zero-wait read straight after a write to the same word
                  // must see the data being committed on this very edge.
                  if (!HWRITE) begin
                     if (mem_we && idx_q == addr_idx) hrdata_d = wr_word;
                     else                             hrdata_d = mem_q[addr_idx];
                  end
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_DONE;
               if (!write_q) hrdata_d = mem_q[idx_q];
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         strb_q   <= '0;
         hrdata_q <= '0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         write_q  <= write_d;
         strb_q   <= strb_d;
         hrdata_q <= hrdata_d;
         mem_q    <= mem_d;
      end
   end

   assign HRDATA    = hrdata_q;
   assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
   assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_mem
//   Two responders share one bus: u_ws1 (WaitStates=1) and u_ws0
//   (WaitStates=0). 'sel' picks the one being addressed; the other sees HSEL
//   low. A pipelined master loop drives transfers from a queue, and a
//   word-array reference model predicts data-phase length, response and data.
// ----------------------------------------------------------------------------
module tb_ahb_slave_mem;

   localparam int W  = 32;
   localparam int AW = 32;
   localparam int D  = 16;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] data;
   } tx_t;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          hsel, hwrite;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic [2:0]    hsize;
   logic [W-1:0]  hwdata;
   logic [W-1:0]  rdata0, rdata1, hrdata;
   logic          ro0, ro1, rsp0, rsp1, hready, hresp;
   int            sel;

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [31:0]   mem_m   [2][D];
   logic [31:0]   last_rd [2];
   tx_t           txq[$];

   always #5 HCLK = ~HCLK;

   assign hready = (sel == 0) ? ro0   : ro1;
   assign hresp  = (sel == 0) ? rsp0  : rsp1;
   assign hrdata = (sel == 0) ? rdata0 : rdata1;

   ahb_slave_mem #(.Width(W), .AddrWidth(AW), .Depth(D), .WaitStates(1)) u_ws1 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && sel == 0), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
      .HREADY(hready), .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(rsp0));

   ahb_slave_mem #(.Width(W), .AddrWidth(AW), .Depth(D), .WaitStates(0)) u_ws0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && sel == 1), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
      .HREADY(hready), .HRDATA(rdata1), .HREADYOUT(ro1), .HRESP(rsp1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
      end
   endtask

   function automatic int ws_of(input int s);
      return (s == 0) ? 1 : 0;
   endfunction

   function automatic bit is_illegal(input tx_t t);
      bit bad;
      bad = (t.addr >= 32'(D * 4));
`ifdef AHB_SLAVE_BYTE_LANE_EN
      case (t.size)
         3'd0: ;
         3'd1: if (t.addr[0]) bad = 1'b1;
         3'd2: if (t.addr[1:0] != 2'b00) bad = 1'b1;
         default: bad = 1'b1;
      endcase
`else
      if (t.size != 3'd2 || t.addr[1:0] != 2'b00) bad = 1'b1;
`endif
      return bad;
   endfunction

   function automatic logic [3:0] lanes_of(input tx_t t);
      case (t.size)
         3'd0:    return 4'b0001 << t.addr[1:0];
         3'd1:    return t.addr[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   task automatic clear_model();
      for (int s = 0; s < 2; s++) begin
         last_rd[s] = '0;
         for (int i = 0; i < D; i++) mem_m[s][i] = '0;
      end
   endtask

   function automatic tx_t mk(input logic [1:0] trans, input logic [31:0] addr,
                              input logic wr, input logic [2:0] size, input logic [31:0] data);
      tx_t t;
      t.sel = 1'b1; t.trans = trans; t.addr = addr; t.wr = wr; t.size = size; t.data = data;
      return t;
   endfunction

   // Pipelined master: entered and left #1 after a rising edge.
   task automatic run_q();
      tx_t  dp;
      bit   dp_v = 0;
      bit   dp_err = 0;
      int   dp_n = 0;
      int   exp_len;
      int   guard = 0;
      logic [3:0] ln;
      while ((txq.size() > 0 || dp_v) && guard < 4000) begin
         guard++;
         if (txq.size() > 0) begin
            hsel = txq[0].sel; htrans = txq[0].trans; haddr = txq[0].addr;
            hwrite = txq[0].wr; hsize = txq[0].size;
         end else begin
            hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
         end
         hwdata = (dp_v && dp.wr) ? dp.data : $urandom();
         @(negedge HCLK);
         if (dp_v) begin
            dp_n++;
            exp_len = dp_err ? 2 : ws_of(sel) + 1;
            chk("hresp", 32'(hresp), 32'(dp_err));
            chk("hready", 32'(hready), 32'(dp_n >= exp_len));
            if (hready) begin
               if (dp_err || dp.wr) begin
                  chk("hrdata_hold", hrdata, last_rd[sel]);
               end else begin
                  chk("rdata", hrdata, mem_m[sel][dp.addr[5:2]]);
                  last_rd[sel] = mem_m[sel][dp.addr[5:2]];
               end
               if (!dp_err && dp.wr) begin
                  ln = lanes_of(dp);
                  for (int k = 0; k < 4; k++)
                     if (ln[k]) mem_m[sel][dp.addr[5:2]][8*k +: 8] = dp.data[8*k +: 8];
               end
            end
         end else begin
            chk("idle_ready", 32'(hready), 32'd1);
            chk("idle_resp", 32'(hresp), 32'd0);
         end
         if (hready) begin
            if (txq.size() > 0) begin
               dp     = txq.pop_front();
               dp_v   = dp.sel && dp.trans[1];
               dp_err = is_illegal(dp);
               dp_n   = 0;
            end else begin
               dp_v = 0;
            end
         end
         @(posedge HCLK); #1;
      end
      chk("drain", 32'(txq.size()) + 32'(dp_v), 32'd0);
      txq.delete();
      hsel = 1'b0; htrans = 2'b00;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tx_t t;
      sel = 0; hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 3'd2; hwdata = 0;
      clear_model();
      HRESET = 1'b1;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_ready0", 32'(ro0), 32'd1);
      chk("rst_resp0", 32'(rsp0), 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_ready1", 32'(ro1), 32'd1);
      chk("rst_resp1", 32'(rsp1), 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      HRESET = 1'b0;
      @(posedge HCLK); #1;

      for (int s = 0; s < 2; s++) begin
         sel = s;
         // Read of fresh memory
         txq.push_back(mk(2'b10, 32'h0, 1'b0, 3'd2, 0));
         run_q();
         // Write then read of the same word, pipelined back to back
         txq.push_back(mk(2'b10, 32'h8, 1'b1, 3'd2, 32'hDEADBEEF));
         txq.push_back(mk(2'b10, 32'h8, 1'b0, 3'd2, 0));
         run_q();
         // Out-of-range read, then a legal read
         txq.push_back(mk(2'b10, 32'h40, 1'b0, 3'd2, 0));
         txq.push_back(mk(2'b10, 32'h0, 1'b0, 3'd2, 0));
         run_q();
         // Word write, byte write at 0x5, read back
         txq.push_back(mk(2'b10, 32'h4, 1'b1, 3'd2, 32'h11223344));
         txq.push_back(mk(2'b10, 32'h5, 1'b1, 3'd0, 32'h0000AA00));
         txq.push_back(mk(2'b10, 32'h4, 1'b0, 3'd2, 0));
         run_q();
         // Sixteen-word burst write, then burst read
         for (int i = 0; i < D; i++)
            txq.push_back(mk(i == 0 ? 2'b10 : 2'b11, 32'(4 * i), 1'b1, 3'd2, 32'(i + 1)));
         for (int i = 0; i < D; i++)
            txq.push_back(mk(i == 0 ? 2'b10 : 2'b11, 32'(4 * i), 1'b0, 3'd2, 0));
         run_q();
         // Random traffic: idle/busy slots, deselects, misaligned and odd sizes
         repeat (150) begin
            t.sel = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 9))
               0:       t.trans = 2'b00;
               1:       t.trans = 2'b01;
               2, 3:    t.trans = 2'b11;
               default: t.trans = 2'b10;
            endcase
            t.addr = 32'($urandom_range(0, 19) * 4);
            if ($urandom_range(0, 7) == 0) t.addr = t.addr + 32'($urandom_range(1, 3));
            t.size = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            t.wr   = 1'($urandom_range(0, 1));
            t.data = $urandom();
            txq.push_back(t);
         end
         run_q();
      end

      // Reset in the middle of a WAIT data phase of a write to 0xC
      sel = 0;
      txq.push_back(mk(2'b10, 32'h4, 1'b0, 3'd2, 0));
      run_q();
      hsel = 1; htrans = 2'b10; haddr = 32'hC; hwrite = 1; hsize = 3'd2;
      @(negedge HCLK);
      chk("rst_pre_ready", 32'(hready), 32'd1);
      @(posedge HCLK); #1;
      hsel = 0; htrans = 2'b00; hwdata = 32'h55;
      @(negedge HCLK);
      chk("rst_in_wait", 32'(hready), 32'd0);
      #1 HRESET = 1'b1;
      #1;
      chk("rst_async_ready", 32'(ro0), 32'd1);
      chk("rst_async_resp", 32'(rsp0), 32'd0);
      chk("rst_async_rdata", rdata0, 32'd0);
      clear_model();
      @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         txq.push_back(mk(2'b10, 32'hC, 1'b0, 3'd2, 0));
         txq.push_back(mk(2'b11, 32'h8, 1'b0, 3'd2, 0));
         run_q();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
